// File: rtl/xc_mmul_unit.sv
// ---------------------------------------------------------------------------
// xc_mmul_unit
//
// Multi-cycle unsigned multiply-accumulate for the wide xc.mmul.3 instruction:
//   {rd_hi, rd_lo} = rs1 * rs2 + rs3
// Iterative shift-add engine. It retires BITS_PER_CYCLE multiplier bits per
// step, so an operation takes N = XLEN / BITS_PER_CYCLE steps. The latency is
// fixed: there is no early exit on zero operands.
//
// Parameters
//   XLEN            operand width (only 32 is supported)
//   BITS_PER_CYCLE  multiplier bits per step: 1, 2, 4 or 8
//
// Ports
//   g_clk       core clock; all state changes on the rising edge
//   g_reset     synchronous reset, active-high; has priority over flush
//   flush       pipeline flush; aborts the operation in any state
//   req_valid   request operands are valid
//   req_ready   unit can accept a request (IDLE only)
//   req_rs1     multiplicand, unsigned
//   req_rs2     multiplier, unsigned
//   req_rs3     addend, unsigned, zero-extended to 2*XLEN
//   rsp_valid   result valid (DONE only)
//   rsp_ready   writeback accepts the result
//   rsp_rd_lo   result[XLEN-1:0]
//   rsp_rd_hi   result[2*XLEN-1:XLEN]
//   busy        operation in flight or result pending (BUSY or DONE)
// ---------------------------------------------------------------------------
module xc_mmul_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs3,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd_lo,
  output logic [XLEN-1:0] rsp_rd_hi,
  output logic            busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [2*XLEN-1:0]   r_mcand;   // multiplicand, shifted left each step
  logic [XLEN-1:0]     r_mplier;  // multiplier shadow, shifted right each step
  logic [2*XLEN-1:0]   r_acc;     // running product + addend
  logic [CW-1:0]       r_cnt;     // completed steps
  logic [XLEN-1:0]     r_rd_lo;
  logic [XLEN-1:0]     r_rd_hi;

  logic                w_accept;
  logic                w_step;
  logic                w_last;
  logic [2*XLEN-1:0]   w_pp;
  logic [2*XLEN-1:0]   w_acc_nxt;

  // -------------------------------------------------------------------------
  // Next-state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end

      S_BUSY: begin
        busy = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        // A flush coinciding with rsp_ready still completes the handshake;
        // either way the result leaves DONE and is never shown again.
        if (flush || rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Partial product for one step: sum of the shifted multiplicand copies
  // selected by the low BITS_PER_CYCLE multiplier bits, modulo 2^(2*XLEN).
  // -------------------------------------------------------------------------
  always_comb begin
    w_pp = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) begin
        w_pp = w_pp + (r_mcand << i);
      end
    end
    w_acc_nxt = r_acc + w_pp;
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rd_lo  <= '0;
      r_rd_hi  <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_mcand  <= {{XLEN{1'b0}}, req_rs1};
        r_mplier <= req_rs2;
        r_acc    <= {{XLEN{1'b0}}, req_rs3};
        r_cnt    <= '0;
      end else if (w_step) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_cnt    <= r_cnt + 1'b1;
      end

      // Result registers load only on the final step, so they keep the
      // last result while the accumulator is reused by the next operation.
      if (w_last) begin
        r_rd_lo <= w_acc_nxt[XLEN-1:0];
        r_rd_hi <= w_acc_nxt[2*XLEN-1:XLEN];
      end
    end
  end

  assign rsp_rd_lo = r_rd_lo;
  assign rsp_rd_hi = r_rd_hi;

endmodule

// File: tb/tb_xc_mmul_unit.sv
// ---------------------------------------------------------------------------
// tb_xc_mmul_unit
//
// Self-checking bench for xc_mmul_unit. Four instances cover
// BITS_PER_CYCLE = 1, 2, 4, 8 (index k -> 1 << k). They share the clock and
// reset, and each instance has its own handshake and operand signals.
// ---------------------------------------------------------------------------
module tb_xc_mmul_unit;

  logic             g_clk;
  logic             g_reset;
  logic [3:0]       flush_v;
  logic [3:0]       req_valid_v;
  logic [3:0]       req_ready_v;
  logic [3:0][31:0] rs1_v;
  logic [3:0][31:0] rs2_v;
  logic [3:0][31:0] rs3_v;
  logic [3:0]       rsp_valid_v;
  logic [3:0]       rsp_ready_v;
  logic [3:0][31:0] lo_v;
  logic [3:0][31:0] hi_v;
  logic [3:0]       busy_v;

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    xc_mmul_unit #(
      .XLEN           (32),
      .BITS_PER_CYCLE (1 << g)
    ) u_dut (
      .g_clk     (g_clk),
      .g_reset   (g_reset),
      .flush     (flush_v[g]),
      .req_valid (req_valid_v[g]),
      .req_ready (req_ready_v[g]),
      .req_rs1   (rs1_v[g]),
      .req_rs2   (rs2_v[g]),
      .req_rs3   (rs3_v[g]),
      .rsp_valid (rsp_valid_v[g]),
      .rsp_ready (rsp_ready_v[g]),
      .rsp_rd_lo (lo_v[g]),
      .rsp_rd_hi (hi_v[g]),
      .busy      (busy_v[g])
    );
  end

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Present a request in the current cycle (accept cycle c); on return the
  // bench sits in cycle c+1.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
    rs1_v[k]       = a;
    rs2_v[k]       = b;
    rs3_v[k]       = c;
    req_valid_v[k] = 1'b1;
    tick();
    req_valid_v[k] = 1'b0;
  endtask

  // Returns the offset from the accept cycle to the first rsp_valid cycle.
  task automatic wait_rsp(input int k, output int lat);
    lat = 1;
    while (!rsp_valid_v[k] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int          lat;
  bit          seen;
  logic [31:0] a, b, c;
  logic [63:0] exp64;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    g_reset     = 1'b1;
    flush_v     = '0;
    req_valid_v = '0;
    rsp_ready_v = '0;
    rs1_v       = '0;
    rs2_v       = '0;
    rs3_v       = '0;
    repeat (3) tick();
    g_reset = 1'b0;

    // Reset state on every instance
    for (int k = 0; k < 4; k++) begin
      chk("rst_req_ready", 64'(req_ready_v[k]), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid_v[k]), 64'd0);
      chk("rst_busy",      64'(busy_v[k]),      64'd0);
      chk("rst_result",    {hi_v[k], lo_v[k]},  64'd0);
    end

    // Basic, BPC=1, rsp_ready high: 3*5+7 = 22, latency 33
    rsp_ready_v[0] = 1'b1;
    issue(0, 32'd3, 32'd5, 32'd7);
    chk("basic_busy_after_accept", 64'(busy_v[0]), 64'd1);
    chk("basic_ready_after_accept", 64'(req_ready_v[0]), 64'd0);
    wait_rsp(0, lat);
    chk("basic_latency", 64'(lat), 64'd33);
    chk("basic_lo", 64'(lo_v[0]), 64'h16);
    chk("basic_hi", 64'(hi_v[0]), 64'h0);
    tick();
    chk("basic_pulse", 64'(rsp_valid_v[0]), 64'd0);
    chk("basic_ready_back", 64'(req_ready_v[0]), 64'd1);
    chk("basic_idle_busy", 64'(busy_v[0]), 64'd0);
    chk("basic_hold_lo", 64'(lo_v[0]), 64'h16);

    // Max operands, BPC=4: (2^32-1)^2 + (2^32-1) = 2^64 - 2^32
    rsp_ready_v[2] = 1'b1;
    issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_rsp(2, lat);
    chk("max_latency", 64'(lat), 64'd9);
    chk("max_result", {hi_v[2], lo_v[2]}, 64'hFFFF_FFFF_0000_0000);
    tick();

    // Backpressure, BPC=1: 0x80000000*4+1 = 0x2_0000_0001
    rsp_ready_v[0] = 1'b0;
    issue(0, 32'h8000_0000, 32'd4, 32'd1);
    wait_rsp(0, lat);
    chk("bp_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 64'(rsp_valid_v[0]), 64'd1);
      chk("bp_result_held", {hi_v[0], lo_v[0]}, 64'h2_0000_0001);
      chk("bp_ready_low", 64'(req_ready_v[0]), 64'd0);
      tick();
    end
    rsp_ready_v[0] = 1'b1;
    chk("bp_valid_at_hs", 64'(rsp_valid_v[0]), 64'd1);
    chk("bp_ready_at_hs", 64'(req_ready_v[0]), 64'd0);
    tick();
    chk("bp_valid_after_hs", 64'(rsp_valid_v[0]), 64'd0);
    chk("bp_ready_after_hs", 64'(req_ready_v[0]), 64'd1);

    // Flush mid-BUSY at step 10; the flushed op must never respond
    issue(0, 32'd9, 32'd9, 32'd9);
    repeat (9) tick();
    flush_v[0] = 1'b1;
    tick();
    flush_v[0] = 1'b0;
    chk("flush_ready", 64'(req_ready_v[0]), 64'd1);
    chk("flush_busy",  64'(busy_v[0]),      64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_v[0]) seen = 1'b1;
      tick();
    end
    chk("flush_no_rsp", 64'(seen), 64'd0);
    // flush together with req_valid in IDLE: no accept
    rs1_v[0]       = 32'd5;
    rs2_v[0]       = 32'd5;
    rs3_v[0]       = 32'd5;
    req_valid_v[0] = 1'b1;
    flush_v[0]     = 1'b1;
    tick();
    req_valid_v[0] = 1'b0;
    flush_v[0]     = 1'b0;
    chk("flush_idle_noaccept_ready", 64'(req_ready_v[0]), 64'd1);
    chk("flush_idle_noaccept_busy",  64'(busy_v[0]),      64'd0);
    issue(0, 32'd2, 32'd2, 32'd0);
    wait_rsp(0, lat);
    chk("post_flush_latency", 64'(lat), 64'd33);
    chk("post_flush_result", {hi_v[0], lo_v[0]}, 64'd4);
    tick();

    // Operand change after accept is ignored, BPC=4
    issue(2, 32'd6, 32'd7, 32'd0);
    rs1_v[2] = 32'h0000_FFFF;
    rs2_v[2] = 32'h0000_FFFF;
    rs3_v[2] = 32'h0000_FFFF;
    wait_rsp(2, lat);
    chk("opchg_result", {hi_v[2], lo_v[2]}, 64'd42);
    tick();

    // Flush in DONE without rsp_ready drops the result, BPC=8
    rsp_ready_v[3] = 1'b0;
    issue(3, 32'd11, 32'd13, 32'd1);
    wait_rsp(3, lat);
    chk("done_flush_latency", 64'(lat), 64'd5);
    chk("done_flush_result", {hi_v[3], lo_v[3]}, 64'd144);
    flush_v[3] = 1'b1;
    tick();
    flush_v[3] = 1'b0;
    chk("done_flush_valid", 64'(rsp_valid_v[3]), 64'd0);
    chk("done_flush_ready", 64'(req_ready_v[3]), 64'd1);

    // Sync reset in DONE, BPC=2: 100*200+300 = 20300
    rsp_ready_v[1] = 1'b0;
    issue(1, 32'd100, 32'd200, 32'd300);
    wait_rsp(1, lat);
    chk("rstdone_latency", 64'(lat), 64'd17);
    chk("rstdone_result", {hi_v[1], lo_v[1]}, 64'd20300);
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    chk("rstdone_valid",  64'(rsp_valid_v[1]), 64'd0);
    chk("rstdone_ready",  64'(req_ready_v[1]), 64'd1);
    chk("rstdone_busy",   64'(busy_v[1]),      64'd0);
    chk("rstdone_result0", {hi_v[1], lo_v[1]}, 64'd0);

    // Random operations across all BITS_PER_CYCLE values (250 each)
    for (int k = 0; k < 4; k++) begin
      rsp_ready_v[k] = 1'b1;
      for (int i = 0; i < 250; i++) begin
        a = $urandom;
        b = $urandom;
        c = $urandom;
        if (i == 0) begin a = '0; b = '0; c = '0; end
        if (i == 1) begin a = '0; end
        if (i == 2) begin b = '1; c = '0; end
        if (i == 3) begin a = '1; b = 32'd1; c = '1; end
        exp64 = 64'(a) * 64'(b) + 64'(c);
        issue(k, a, b, c);
        wait_rsp(k, lat);
        chk("rand_latency", 64'(lat), 64'((32 >> k) + 1));
        chk("rand_result", {hi_v[k], lo_v[k]}, exp64);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
